// File: rtl/stack_pkg.sv
// Shared opcode and select definitions for param_stack.
// ROT opcode is only decoded when STACK_ROT_EN is defined.
package stack_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP  = 3'b000;
    localparam op_t OP_PUSH = 3'b001;
    localparam op_t OP_POP  = 3'b010;
    localparam op_t OP_EXCH = 3'b011;
    localparam op_t OP_DUP  = 3'b100;
    localparam op_t OP_CLR  = 3'b101;
    localparam op_t OP_ROT  = 3'b110;

    // Per-entry next-value source for the register array.
    typedef enum logic [2:0] {
        SRC_HOLD = 3'd0,
        SRC_DIN  = 3'd1,
        SRC_ZERO = 3'd2,
        SRC_UP1  = 3'd3,
        SRC_DN1  = 3'd4,
        SRC_DN2  = 3'd5
    } src_t;

endpackage

// File: rtl/stack_ctl.sv
// Decodes the stack opcode against the occupancy into entry selects,
// next count and flag updates. STACK_ROT_EN enables the ROT opcode.
module stack_ctl
    import stack_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  op_t                   op,
    input  logic [CW-1:0]         count,
    output src_t [DEPTH-1:0]      sel,
    output logic [CW-1:0]         cnt_nxt,
    output logic                  flg_we,
    output logic                  ovr_d,
    output logic                  und_d
);

    int c;

    always_comb begin
        c       = int'(count);
        cnt_nxt = count;
        flg_we  = 1'b0;
        ovr_d   = 1'b0;
        und_d   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = SRC_HOLD;
        end

        unique case (1'b1)
            op == OP_PUSH: begin
                flg_we = 1'b1;
                if (c == DEPTH) begin
                    ovr_d = 1'b1;
                end else begin
                    cnt_nxt = count + 1'b1;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i == c) sel[i] = SRC_DIN;
                    end
                end
            end
            op == OP_POP: begin
                flg_we = 1'b1;
                if (c == 0) begin
                    und_d = 1'b1;
                end else begin
                    cnt_nxt = count - 1'b1;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i == c - 1) sel[i] = SRC_ZERO;
                    end
                end
            end
            op == OP_EXCH: begin
                flg_we = 1'b1;
                if (c < 2) begin
                    und_d = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i == c - 1) sel[i] = SRC_DN1;
                        if (i == c - 2) sel[i] = SRC_UP1;
                    end
                end
            end
            op == OP_DUP: begin
                flg_we = 1'b1;
                if (c == 0) begin
                    und_d = 1'b1;
                end else if (c == DEPTH) begin
                    ovr_d = 1'b1;
                end else begin
                    cnt_nxt = count + 1'b1;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i == c) sel[i] = SRC_DN1;
                    end
                end
            end
            op == OP_CLR: begin
                flg_we  = 1'b1;
                cnt_nxt = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    sel[i] = SRC_ZERO;
                end
            end
`ifdef STACK_ROT_EN
            op == OP_ROT: begin
                flg_we = 1'b1;
                if (c < 3) begin
                    und_d = 1'b1;
                end else begin
                    // bottom of the three takes the middle, top wraps down
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i == c - 3) sel[i] = SRC_UP1;
                        if (i == c - 2) sel[i] = SRC_UP1;
                        if (i == c - 1) sel[i] = SRC_DN2;
                    end
                end
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack, one encoded op per falling clock edge.
// Define STACK_ROT_EN to enable the three-entry rotate opcode.
module param_stack
    import stack_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   ctl,
    input  logic                   rst,
    input  logic [2:0]             op,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       top,
    output logic [WIDTH-1:0]       nxt,
    output logic [CW-1:0]          count,
    output logic                   full,
    output logic                   empty,
    output logic                   over,
    output logic                   under,
    output logic [WIDTH*DEPTH-1:0] dump
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] up1 [DEPTH];
    logic [WIDTH-1:0] dn1 [DEPTH];
`ifdef STACK_ROT_EN
    logic [WIDTH-1:0] dn2 [DEPTH];
`endif

    src_t [DEPTH-1:0] sel;
    logic [CW-1:0]    cnt_nxt;
    logic             flg_we;
    logic             ovr_d;
    logic             und_d;

    stack_ctl #(
        .DEPTH (DEPTH)
    ) u_ctl (
        .op      (op),
        .count   (count),
        .sel     (sel),
        .cnt_nxt (cnt_nxt),
        .flg_we  (flg_we),
        .ovr_d   (ovr_d),
        .und_d   (und_d)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_nb
        if (i + 1 < DEPTH) begin : g_up
            assign up1[i] = mem[i+1];
        end else begin : g_up0
            assign up1[i] = '0;
        end
        if (i > 0) begin : g_dn
            assign dn1[i] = mem[i-1];
        end else begin : g_dn0
            assign dn1[i] = '0;
        end
`ifdef STACK_ROT_EN
        if (i > 1) begin : g_dn2
            assign dn2[i] = mem[i-2];
        end else begin : g_dn20
            assign dn2[i] = '0;
        end
`endif
        assign dump[i*WIDTH +: WIDTH] = mem[i];
    end

    always_ff @(negedge ctl or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            count <= '0;
            over  <= 1'b0;
            under <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                unique case (sel[i])
                    SRC_DIN:  mem[i] <= din;
                    SRC_ZERO: mem[i] <= '0;
                    SRC_UP1:  mem[i] <= up1[i];
                    SRC_DN1:  mem[i] <= dn1[i];
`ifdef STACK_ROT_EN
                    SRC_DN2:  mem[i] <= dn2[i];
`endif
                    default: begin
                    end
                endcase
            end
            count <= cnt_nxt;
            if (flg_we) begin
                over  <= ovr_d;
                under <= und_d;
            end
        end
    end

    // slots above count are always zero, so empty reads fall out as 0
    always_comb begin
        top = '0;
        nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(count) - 1) top = mem[i];
            if (i == int'(count) - 2) nxt = mem[i];
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack at WIDTH=4, DEPTH=4.
// ROT expectations follow whether STACK_ROT_EN is defined.
module tb_param_stack;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] PUSH = 3'b001;
    localparam logic [2:0] POP  = 3'b010;
    localparam logic [2:0] EXCH = 3'b011;
    localparam logic [2:0] DUP  = 3'b100;
    localparam logic [2:0] CLR  = 3'b101;
    localparam logic [2:0] ROT  = 3'b110;
    localparam logic [2:0] NOP7 = 3'b111;

    logic        ctl;
    logic        rst;
    logic [2:0]  op;
    logic [3:0]  din;
    logic [3:0]  top;
    logic [3:0]  nxt;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        over;
    logic        under;
    logic [15:0] dump;

    int n_chk;
    int n_err;

    param_stack #(
        .WIDTH (4),
        .DEPTH (4)
    ) dut (
        .ctl   (ctl),
        .rst   (rst),
        .op    (op),
        .din   (din),
        .top   (top),
        .nxt   (nxt),
        .count (count),
        .full  (full),
        .empty (empty),
        .over  (over),
        .under (under),
        .dump  (dump)
    );

    initial begin
        ctl = 1'b1;
        forever #5 ctl = ~ctl;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [3:0] d);
        op  = o;
        din = d;
        @(negedge ctl);
        #1;
        op  = NOP;
        din = '0;
    endtask

    task automatic chk_flags(input string tag, input logic ov,
                             input logic un);
        chk({tag, ".over"}, 32'(over), 32'(ov));
        chk({tag, ".under"}, 32'(under), 32'(un));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b0;
        op    = NOP;
        din   = '0;
        #12;
        chk("rst.count", 32'(count), 0);
        chk("rst.top", 32'(top), 0);
        chk("rst.nxt", 32'(nxt), 0);
        chk("rst.full", 32'(full), 0);
        chk("rst.empty", 32'(empty), 1);
        chk_flags("rst", 1'b0, 1'b0);
        chk("rst.dump", 32'(dump), 0);
        rst = 1'b1;

        do_op(PUSH, 4'h3);
        chk("push1.top", 32'(top), 32'h3);
        chk("push1.empty", 32'(empty), 0);
        do_op(PUSH, 4'h5);
        do_op(PUSH, 4'h9);
        chk("push3.full", 32'(full), 0);
        do_op(PUSH, 4'hC);
        chk("push4.count", 32'(count), 4);
        chk("push4.full", 32'(full), 1);
        chk("push4.top", 32'(top), 32'hC);
        chk("push4.nxt", 32'(nxt), 32'h9);
        chk("push4.dump", 32'(dump), 32'hC953);

        do_op(PUSH, 4'h7);
        chk("ovf.count", 32'(count), 4);
        chk_flags("ovf", 1'b1, 1'b0);
        chk("ovf.dump", 32'(dump), 32'hC953);
        do_op(NOP7, 4'h0);
        chk_flags("nop7", 1'b1, 1'b0);
        do_op(POP, 4'h0);
        chk_flags("pop", 1'b0, 1'b0);
        chk("pop.count", 32'(count), 3);
        chk("pop.top", 32'(top), 32'h9);
        chk("pop.full", 32'(full), 0);
        chk("pop.dump", 32'(dump), 32'h0953);

        do_op(CLR, 4'h0);
        chk("clr.count", 32'(count), 0);
        chk("clr.dump", 32'(dump), 0);
        do_op(POP, 4'h0);
        chk_flags("udf_pop", 1'b0, 1'b1);
        do_op(EXCH, 4'h0);
        chk_flags("udf_exch", 1'b0, 1'b1);
        chk("udf.count", 32'(count), 0);
        chk("udf.top", 32'(top), 0);
        chk("udf.nxt", 32'(nxt), 0);
        chk("udf.dump", 32'(dump), 0);
        do_op(PUSH, 4'hA);
        chk_flags("pushA", 1'b0, 1'b0);
        chk("pushA.top", 32'(top), 32'hA);

        do_op(CLR, 4'h0);
        do_op(PUSH, 4'h3);
        do_op(PUSH, 4'h5);
        do_op(EXCH, 4'h0);
        chk("exch.top", 32'(top), 32'h3);
        chk("exch.nxt", 32'(nxt), 32'h5);
        chk("exch.dump", 32'(dump), 32'h0035);
        do_op(DUP, 4'h0);
        chk("dup.count", 32'(count), 3);
        chk("dup.top", 32'(top), 32'h3);
        chk("dup.nxt", 32'(nxt), 32'h3);
        chk("dup.dump", 32'(dump), 32'h0335);
        do_op(DUP, 4'h0);
        chk("dup4.full", 32'(full), 1);
        do_op(DUP, 4'h0);
        chk_flags("dupfull", 1'b1, 1'b0);
        chk("dupfull.dump", 32'(dump), 32'h3335);
        do_op(CLR, 4'h0);
        chk_flags("clr2", 1'b0, 1'b0);
        do_op(DUP, 4'h0);
        chk_flags("dupempty", 1'b0, 1'b1);
        do_op(PUSH, 4'h1);
        do_op(EXCH, 4'h0);
        chk_flags("exch1", 1'b0, 1'b1);

        do_op(CLR, 4'h0);
        do_op(PUSH, 4'h1);
        do_op(PUSH, 4'h2);
        do_op(PUSH, 4'h3);
        do_op(ROT, 4'h0);
`ifdef STACK_ROT_EN
        chk("rot.dump", 32'(dump), 32'h0132);
        chk("rot.top", 32'(top), 32'h1);
`else
        chk("rot.dump", 32'(dump), 32'h0321);
        chk("rot.top", 32'(top), 32'h3);
`endif
        chk("rot.count", 32'(count), 3);
        chk_flags("rot", 1'b0, 1'b0);

        #2;
        rst = 1'b0;
        #2;
        chk("arst.count", 32'(count), 0);
        chk("arst.dump", 32'(dump), 0);
        chk("arst.empty", 32'(empty), 1);
        chk_flags("arst", 1'b0, 1'b0);
        rst = 1'b1;
        do_op(PUSH, 4'h6);
        chk("arst_push.count", 32'(count), 1);
        chk("arst_push.top", 32'(top), 32'h6);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
